// File: rtl/adc_trig_pkg.sv
// Shared types and helpers for the ADC threshold trigger.
package adc_trig_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StActive,
        StHoldoff
    } trig_state_e;

    // Unsigned saturation of a product to an out_w-bit ceiling.
    function automatic logic [63:0] sat_u(input logic [63:0] prod, input int unsigned out_w);
        logic [63:0] max_v;
        max_v = (64'd1 << out_w) - 64'd1;
        return (prod > max_v) ? max_v : prod;
    endfunction

endpackage

// File: rtl/trig_scale.sv
// Registered pulse datapath: baseline subtract, clamp at zero, gain multiply, saturate.
module trig_scale
    import adc_trig_pkg::*;
#(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned GAIN_W = 8,
    parameter int unsigned OUT_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              falling,
    input  logic [DATA_W-1:0] adc_in,
    input  logic [DATA_W-1:0] baseline,
    input  logic [GAIN_W-1:0] gain,
    output logic [OUT_W-1:0]  pulse_out,
    output logic              pulse_valid
);

    localparam int unsigned PW = DATA_W + GAIN_W;

    logic [DATA_W-1:0] diff;
    logic [PW-1:0]     prod;
    logic [OUT_W-1:0]  pulse_d, pulse_q;
    logic              valid_d, valid_q;

    always_comb begin
        diff = '0;
        if (falling) begin
            if (baseline > adc_in) diff = baseline - adc_in;
        end else begin
            if (adc_in > baseline) diff = adc_in - baseline;
        end
        prod = {{GAIN_W{1'b0}}, diff} * {{DATA_W{1'b0}}, gain};

        pulse_d = pulse_q;
        if (clear) begin
            pulse_d = '0;
        end else if (load) begin
            pulse_d = OUT_W'(sat_u(64'(prod), OUT_W));
        end
        valid_d = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            valid_q <= valid_d;
        end
    end

    assign pulse_out   = pulse_q;
    assign pulse_valid = valid_q;

endmodule

// File: rtl/adc_threshold_trigger.sv
// Clocked ADC threshold trigger with hysteresis, holdoff and scaled pulse output.
// Optional peak tracking outputs are enabled by defining TRIG_PEAK_HOLD_EN.
module adc_threshold_trigger
    import adc_trig_pkg::*;
#(
    parameter int unsigned DATA_W  = 14,
    parameter int unsigned GAIN_W  = 8,
    parameter int unsigned OUT_W   = 14,
    parameter int unsigned HYST    = 16,
    parameter int unsigned HOLDOFF = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_in,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] threshold,
    input  logic [DATA_W-1:0] baseline,
    input  logic [GAIN_W-1:0] gain,
    input  logic              falling,
    input  logic              arm,
    output logic              trigger,
    output logic              active,
    output logic [OUT_W-1:0]  pulse_out,
    output logic              pulse_valid,
    output logic [CNT_W-1:0]  event_count
`ifdef TRIG_PEAK_HOLD_EN
    ,
    output logic [OUT_W-1:0]  peak_out,
    output logic              peak_valid
`endif
);

    localparam int unsigned     HoW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HoW-1:0]  HoLast = HoW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam int unsigned     XW     = DATA_W + 1;
    localparam logic [XW-1:0]   HystX  = XW'(HYST);
    localparam logic [XW-1:0]   MaxX   = XW'((64'd1 << DATA_W) - 64'd1);

    trig_state_e      state_d, state_q;
    logic [HoW-1:0]   cnt_d, cnt_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             trig_d, trig_q;
    logic             load, clear;

    logic [XW-1:0] thr_x, adc_x, exit_lo, exit_hi, hi_sum;
    logic          crossing, exit_cond;

    // Exit bounds are widened one bit so threshold +/- HYST clamps instead of wrapping.
    always_comb begin
        thr_x    = {1'b0, threshold};
        adc_x    = {1'b0, adc_in};
        exit_lo  = (thr_x >= HystX) ? thr_x - HystX : '0;
        hi_sum   = thr_x + HystX;
        exit_hi  = (hi_sum > MaxX) ? MaxX : hi_sum;
        crossing = falling ? (adc_in < threshold) : (adc_in > threshold);
        exit_cond = falling ? (adc_x > exit_hi) : (adc_x < exit_lo);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        trig_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arm) state_d = StArmed;
            end
            StArmed: begin
                if (!arm) begin
                    state_d = StIdle;
                end else if (adc_valid && crossing) begin
                    state_d = StActive;
                    trig_d  = 1'b1;
                    load    = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            StActive: begin
                if (adc_valid) begin
                    load = 1'b1;
                    if (exit_cond) begin
                        state_d = (HOLDOFF > 0) ? StHoldoff : StArmed;
                        cnt_d   = '0;
                    end
                end
            end
            StHoldoff: begin
                if (cnt_q == HoLast) begin
                    cnt_d   = '0;
                    state_d = arm ? StArmed : StIdle;
                end else begin
                    cnt_d = cnt_q + HoW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        clear = (state_d == StIdle) && (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            count_q <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            trig_q  <= trig_d;
        end
    end

    trig_scale #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W),
        .OUT_W  (OUT_W)
    ) u_scale (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .clear       (clear),
        .falling     (falling),
        .adc_in      (adc_in),
        .baseline    (baseline),
        .gain        (gain),
        .pulse_out   (pulse_out),
        .pulse_valid (pulse_valid)
    );

    assign trigger     = trig_q;
    assign active      = (state_q == StActive);
    assign event_count = count_q;

`ifdef TRIG_PEAK_HOLD_EN
    logic [OUT_W-1:0] peak_d, peak_q;
    logic             peakv_d, peakv_q;

    // The exit sample's pulse lands after ACTIVE is left, so it closes the event.
    always_comb begin
        peak_d = peak_q;
        if (trig_q) begin
            peak_d = pulse_out;
        end else if (pulse_valid && pulse_out > peak_q) begin
            peak_d = pulse_out;
        end
        peakv_d = pulse_valid && (state_q != StActive);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q  <= '0;
            peakv_q <= 1'b0;
        end else begin
            peak_q  <= peak_d;
            peakv_q <= peakv_d;
        end
    end

    assign peak_out   = peak_q;
    assign peak_valid = peakv_q;
`else
    // Peak tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_adc_threshold_trigger.sv
// Self-checking bench for adc_threshold_trigger: directed cases then randomized traffic.
module tb_adc_threshold_trigger;

    localparam int unsigned DATA_W  = 14;
    localparam int unsigned GAIN_W  = 8;
    localparam int unsigned OUT_W   = 14;
    localparam int unsigned HYST    = 16;
    localparam int unsigned HOLDOFF = 64;
    localparam int unsigned CNT_W   = 16;
    localparam int          MAX_IN  = (1 << DATA_W) - 1;
    localparam int          MAX_OUT = (1 << OUT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] adc_in;
    logic              adc_valid;
    logic [DATA_W-1:0] threshold;
    logic [DATA_W-1:0] baseline;
    logic [GAIN_W-1:0] gain;
    logic              falling;
    logic              arm;
    logic              trigger;
    logic              active;
    logic [OUT_W-1:0]  pulse_out;
    logic              pulse_valid;
    logic [CNT_W-1:0]  event_count;

    adc_threshold_trigger #(
        .DATA_W  (DATA_W),
        .GAIN_W  (GAIN_W),
        .OUT_W   (OUT_W),
        .HYST    (HYST),
        .HOLDOFF (HOLDOFF),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adc_in      (adc_in),
        .adc_valid   (adc_valid),
        .threshold   (threshold),
        .baseline    (baseline),
        .gain        (gain),
        .falling     (falling),
        .arm         (arm),
        .trigger     (trigger),
        .active      (active),
        .pulse_out   (pulse_out),
        .pulse_valid (pulse_valid),
        .event_count (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a waiting flag, an in-event flag and a holdoff countdown.
    bit m_waiting;
    bit m_in_event;
    int m_hold;
    bit m_trig;
    bit m_pv;
    int m_pulse;
    int m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_pulse(input int adc);
        int diff;
        int prod;
        diff = falling ? int'(baseline) - adc : adc - int'(baseline);
        if (diff < 0) diff = 0;
        prod = diff * int'(gain);
        return (prod > MAX_OUT) ? MAX_OUT : prod;
    endfunction

    function automatic bit ref_cross(input int adc);
        return falling ? (adc < int'(threshold)) : (adc > int'(threshold));
    endfunction

    function automatic bit ref_exit(input int adc);
        int lo;
        int hi;
        lo = int'(threshold) - int'(HYST);
        if (lo < 0) lo = 0;
        hi = int'(threshold) + int'(HYST);
        if (hi > MAX_IN) hi = MAX_IN;
        return falling ? (adc > hi) : (adc < lo);
    endfunction

    task automatic model_edge();
        int adc;
        adc    = int'(adc_in);
        m_trig = 1'b0;
        m_pv   = 1'b0;
        if (m_in_event) begin
            if (adc_valid) begin
                m_pulse = ref_pulse(adc);
                m_pv    = 1'b1;
                if (ref_exit(adc)) begin
                    m_in_event = 1'b0;
                    if (HOLDOFF > 0) m_hold = HOLDOFF;
                    else m_waiting = 1'b1;
                end
            end
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
                m_waiting = arm;
                if (!arm) m_pulse = 0;
            end
        end else if (m_waiting) begin
            if (!arm) begin
                m_waiting = 1'b0;
                m_pulse   = 0;
            end else if (adc_valid && ref_cross(adc)) begin
                m_waiting  = 1'b0;
                m_in_event = 1'b1;
                m_trig     = 1'b1;
                m_pulse    = ref_pulse(adc);
                m_pv       = 1'b1;
                m_count    = (m_count + 1) % (1 << CNT_W);
            end
        end else if (arm) begin
            m_waiting = 1'b1;
        end
    endtask

    task automatic step(input int adc, input bit vld);
        @(negedge clk);
        adc_in    = DATA_W'(adc);
        adc_valid = vld;
        @(posedge clk);
        model_edge();
        #1;
        check("trigger", 32'(trigger), 32'(m_trig));
        check("active", 32'(active), 32'(m_in_event));
        check("pulse_valid", 32'(pulse_valid), 32'(m_pv));
        check("pulse_out", 32'(pulse_out), 32'(m_pulse));
        check("event_count", 32'(event_count), 32'(m_count));
    endtask

    // Asserted mid-cycle so the asynchronous clear is observed without a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_trigger", 32'(trigger), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_pulse_valid", 32'(pulse_valid), 32'd0);
        check("rst_pulse_out", 32'(pulse_out), 32'd0);
        check("rst_event_count", 32'(event_count), 32'd0);
        m_waiting  = 1'b0;
        m_in_event = 1'b0;
        m_hold     = 0;
        m_trig     = 1'b0;
        m_pv       = 1'b0;
        m_pulse    = 0;
        m_count    = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int a;
        rst_n     = 1'b0;
        adc_in    = '0;
        adc_valid = 1'b0;
        threshold = DATA_W'(8190);
        baseline  = DATA_W'(8000);
        gain      = GAIN_W'(10);
        falling   = 1'b0;
        arm       = 1'b0;
        #2;
        do_reset();

        // Rising trigger and saturation.
        arm = 1'b1;
        step(0, 1'b0);
        step(8191, 1'b1);
        check("tp1_trigger", 32'(trigger), 32'd1);
        check("tp1_pulse", 32'(pulse_out), 32'd1910);
        check("tp1_count", 32'(event_count), 32'd1);
        step(100, 1'b1);
        repeat (HOLDOFF) step(9000, 1'b1);
        step(16383, 1'b1);
        check("tp2_saturate", 32'(pulse_out), 32'd16383);

        // Hysteresis exit, holdoff ignores a crossing, then retrigger.
        step(8200, 1'b1);
        step(8180, 1'b1);
        check("hyst_stay", 32'(active), 32'd1);
        step(8173, 1'b1);
        check("hyst_exit", 32'(active), 32'd0);
        step(9000, 1'b1);
        check("holdoff_ignore", 32'(trigger), 32'd0);
        repeat (HOLDOFF - 1) step(9000, 1'b1);
        step(9000, 1'b1);
        check("retrigger", 32'(trigger), 32'd1);

        // Disarm inside an event: event completes, then idles.
        arm = 1'b0;
        step(9000, 1'b1);
        check("disarm_active", 32'(active), 32'd1);
        step(0, 1'b1);
        repeat (HOLDOFF) step(0, 1'b0);
        repeat (5) step(9000, 1'b1);
        check("disarm_count", 32'(event_count), 32'd3);
        check("disarm_pulse_cleared", 32'(pulse_out), 32'd0);

        // Falling polarity.
        falling   = 1'b1;
        threshold = DATA_W'(2000);
        baseline  = DATA_W'(8000);
        gain      = GAIN_W'(2);
        arm       = 1'b1;
        step(5000, 1'b0);
        step(1000, 1'b1);
        check("fall_trigger", 32'(trigger), 32'd1);
        check("fall_pulse", 32'(pulse_out), 32'd14000);

        // Reset mid-event, then a fresh event counts from one.
        do_reset();
        step(0, 1'b0);
        step(1000, 1'b1);
        check("post_rst_count", 32'(event_count), 32'd1);
        arm = 1'b0;
        step(5000, 1'b1);
        repeat (HOLDOFF) step(0, 1'b0);

        // Full-scale rising threshold can never fire.
        falling   = 1'b0;
        threshold = DATA_W'(MAX_IN);
        arm       = 1'b1;
        repeat (10) step(MAX_IN, 1'b1);
        check("never_trig_count", 32'(event_count), 32'd1);

        // Randomized traffic; controls only change while idle and disarmed.
        for (int i = 0; i < 3000; i++) begin
            if (!m_waiting && !m_in_event && m_hold == 0 && !arm && $urandom_range(0, 3) == 0) begin
                falling   = 1'($urandom_range(0, 1));
                threshold = DATA_W'($urandom_range(0, MAX_IN));
                if ($urandom_range(0, 7) == 0) threshold = falling ? '0 : DATA_W'(MAX_IN);
                baseline  = DATA_W'($urandom_range(0, MAX_IN));
                gain      = GAIN_W'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 39) == 0) arm = ~arm;
            if ($urandom_range(0, 3) == 0) begin
                a = int'($urandom_range(0, MAX_IN));
            end else begin
                a = int'(threshold) + int'($urandom_range(0, 80)) - 40;
                if (a < 0) a = 0;
                if (a > MAX_IN) a = MAX_IN;
            end
            step(a, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
